// File: rtl/game_sequencer_if.sv
// Game-flow bus between the Pacman sequencer and its neighbours.
// Carries the input strobes from the debouncers, ghost and movement logic
// and the registered control/status outputs toward display and score.
interface game_sequencer_if;
   logic        frame_tick;
   logic        start;
   logic        ack;
   logic        ghost_hit;
   logic        pellet_eaten;
   logic        maze_clear;
   logic        move_en;
   logic        entity_reset;
   logic [2:0]  state;
   logic [1:0]  lives;
   logic [3:0]  level;
   logic [15:0] score;
   logic        win;
   logic        lose;

   modport master (
      output frame_tick, start, ack, ghost_hit, pellet_eaten, maze_clear,
      input  move_en, entity_reset, state, lives, level, score, win, lose
   );

   modport slave (
      input  frame_tick, start, ack, ghost_hit, pellet_eaten, maze_clear,
      output move_en, entity_reset, state, lives, level, score, win, lose
   );
endinterface

// File: rtl/game_sequencer.sv
// Pacman round life-cycle controller: idle, ready countdown, play, death
// animation, level-up and game over. Gates movement, issues entity reset
// pulses and keeps lives, level and a saturating 4-digit BCD score.
module game_sequencer #(
   parameter int LIVES_INIT   = 3,
   parameter int READY_FRAMES = 60,
   parameter int DEATH_FRAMES = 120,
   parameter int LEVEL_FRAMES = 90,
   parameter int PELLET_PTS   = 1
) (
   input logic              clk,
   input logic              reset,
   game_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      READY     = 3'd1,
      PLAY      = 3'd2,
      DYING     = 3'd3,
      LEVEL_UP  = 3'd4,
      GAME_OVER = 3'd5
   } state_t;

   localparam logic [7:0] READY_LAST = 8'(READY_FRAMES - 1);
   localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
   localparam logic [7:0] LEVEL_LAST = 8'(LEVEL_FRAMES - 1);
   localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);
   localparam logic [3:0] PTS        = 4'(PELLET_PTS);

   state_t      state_q;
   state_t      state_d;
   logic [7:0]  frame_cnt;
   logic [1:0]  lives_q;
   logic [3:0]  level_q;
   logic [15:0] score_q;
   logic        move_en_q;
   logic        entity_reset_q;
   logic        win_q;
   logic        lose_q;

   logic        entity_reset_d;
   logic        game_init;
   logic        lives_dec;
   logic        level_inc;
   logic        score_add;
   logic        timed_state;

   // Adds pts to a 4-digit BCD value with decimal carry; an overflow out of
   // the thousands digit pins the result at 9999.
   function automatic logic [15:0] bcd_add_sat(input logic [15:0] value,
                                               input logic [3:0]  pts);
      logic [15:0] sum;
      logic [4:0]  digit;
      logic        carry;
      sum   = '0;
      carry = 1'b0;
      for (int i = 0; i < 4; i++) begin
         digit = {1'b0, value[4*i +: 4]} + {1'b0, (i == 0) ? pts : 4'd0}
               + {4'd0, carry};
         if (digit > 5'd9) begin
            digit = digit - 5'd10;
            carry = 1'b1;
         end else begin
            carry = 1'b0;
         end
         sum[4*i +: 4] = digit[3:0];
      end
      return carry ? 16'h9999 : sum;
   endfunction

   // Next-state decode plus the one-cycle side effects of each transition.
   always_comb begin
      state_d        = state_q;
      entity_reset_d = 1'b0;
      game_init      = 1'b0;
      lives_dec      = 1'b0;
      level_inc      = 1'b0;
      score_add      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d        = READY;
               game_init      = 1'b1;
               entity_reset_d = 1'b1;
            end
         end
         READY: begin
            if (bus.frame_tick && frame_cnt == READY_LAST)
               state_d = PLAY;
         end
         PLAY: begin
            score_add = bus.pellet_eaten;
            if (bus.maze_clear) begin
               state_d = LEVEL_UP;
            end else if (bus.ghost_hit) begin
               state_d   = DYING;
               lives_dec = 1'b1;
            end
         end
         DYING: begin
            if (bus.frame_tick && frame_cnt == DEATH_LAST) begin
               if (lives_q == 2'd0) begin
                  state_d = GAME_OVER;
               end else begin
                  state_d        = READY;
                  entity_reset_d = 1'b1;
               end
            end
         end
         LEVEL_UP: begin
            if (bus.frame_tick && frame_cnt == LEVEL_LAST) begin
               state_d        = READY;
               entity_reset_d = 1'b1;
               level_inc      = 1'b1;
            end
         end
         GAME_OVER: begin
            if (bus.ack)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign timed_state = (state_q == READY) || (state_q == DYING) ||
                        (state_q == LEVEL_UP);

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Frame counter restarts on every state entry and counts ticks in timed states.
   always_ff @(posedge clk) begin
      if (reset)
         frame_cnt <= '0;
      else if (state_d != state_q)
         frame_cnt <= '0;
      else if (bus.frame_tick && timed_state)
         frame_cnt <= frame_cnt + 8'd1;
   end

   // Game bookkeeping: lives, level and score, reloaded on game start.
   always_ff @(posedge clk) begin
      if (reset) begin
         score_q <= '0;
         lives_q <= LIVES_LOAD;
         level_q <= 4'd1;
      end else if (game_init) begin
         score_q <= '0;
         lives_q <= LIVES_LOAD;
         level_q <= 4'd1;
      end else begin
         if (score_add)
            score_q <= bcd_add_sat(score_q, PTS);
         if (lives_dec)
            lives_q <= lives_q - 2'd1;
         if (level_inc && level_q != 4'd15)
            level_q <= level_q + 4'd1;
      end
   end

   // Registered outputs decoded from the upcoming state so they line up with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         move_en_q      <= 1'b0;
         entity_reset_q <= 1'b0;
         win_q          <= 1'b0;
         lose_q         <= 1'b0;
      end else begin
         move_en_q      <= (state_d == PLAY);
         entity_reset_q <= entity_reset_d;
         win_q          <= (state_d == LEVEL_UP);
         lose_q         <= (state_d == GAME_OVER);
      end
   end

   assign bus.state        = 3'(state_q);
   assign bus.move_en      = move_en_q;
   assign bus.entity_reset = entity_reset_q;
   assign bus.win          = win_q;
   assign bus.lose         = lose_q;
   assign bus.lives        = lives_q;
   assign bus.level        = level_q;
   assign bus.score        = score_q;

endmodule
